// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result path.
//   - opcode tags carried alongside each ALU result
//   - frame/payload widths and the line levels of the start/stop bits
//   - serializer FSM state type
//   - payload record and a helper that wraps a payload into a serial frame
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_ENC = 4'd8
  } opcode_t;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned PAYLOAD_W = 14;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Field order matches the on-wire order after the start bit.
  typedef struct packed {
    logic [3:0] opcode;
    logic       carry;
    logic       overflow;
    logic [7:0] result;
  } payload_t;

  // Frame is transmitted MSB first: start, payload, stop.
  function automatic logic [FRAME_W-1:0] build_frame(input payload_t p);
    return {START_BIT, p, STOP_BIT};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: small synchronous FIFO holding captured ALU results.
//   clk, rst     : clock, synchronous active-high reset
//   push         : write request; ignored while full (even if popping)
//   push_data    : entry to store
//   pop          : read request; ignored while empty
//   pop_data     : head entry (show-ahead, valid whenever !empty)
//   full, empty  : status derived from the registered count
//   count        : number of stored entries (0..DEPTH)
module result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: queues ALU results and shifts each one out as a
// fixed 16-bit frame on a single wire.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : ALU result valid this cycle
//   in_ready      : FIFO can accept (not full); combinational
//   in_result     : ALU result byte
//   in_carry      : carry/borrow flag
//   in_overflow   : signed-overflow flag
//   in_opcode     : opcode tag of the result
//   ser_out       : serial data, idles high
//   ser_busy      : high while a frame is on the line
//   frame_done    : one-cycle pulse on the last cycle of a stop bit
//   fifo_count    : entries currently queued
// Frame: start(0), opcode[3:0], carry, overflow, result[7:0], stop(1),
// MSB first, each bit held BIT_CYCLES clocks.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_result,
  input  logic                       in_carry,
  input  logic                       in_overflow,
  input  logic [3:0]                 in_opcode,
  output logic                       ser_out,
  output logic                       ser_busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam bit          SINGLE   = (BIT_CYCLES == 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = (BIT_CYCLES >= 2) ? CW'(BIT_CYCLES - 2) : '0;
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_W - 1);
  localparam logic [3:0]  PEN_IDX  = 4'(FRAME_W - 2);

  payload_t               push_payload;
  logic [PAYLOAD_W-1:0]   head_bits;
  payload_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  state_t                 state;
  logic [FRAME_W-1:0]     shreg;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   bit_end;
  logic                   last_bit;
  logic [FRAME_W-1:0]     next_frame;

  assign push_payload = '{opcode: in_opcode, carry: in_carry,
                          overflow: in_overflow, result: in_result};
  assign head         = payload_t'(head_bits);
  assign next_frame   = build_frame(head);
  assign in_ready     = !fifo_full;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_payload),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_end  = (cnt == CNT_LAST);
  assign last_bit = (bit_idx == LAST_IDX);

  // A new frame is taken either from idle or on the final cycle of a stop
  // bit, which is what gives gap-free back-to-back frames.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == SEND) && bit_end && last_bit));

  // The line is driven straight from the shift register MSB; ones are
  // shifted in behind the frame so the line rests high after the stop bit.
  assign ser_out = shreg[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '1;
      cnt        <= '0;
      bit_idx    <= '0;
      ser_busy   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      unique case (state)
        IDLE: begin
          ser_busy <= 1'b0;
        end
        SEND: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_bit) begin
              state    <= IDLE;
              ser_busy <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              shreg   <= {shreg[FRAME_W-2:0], STOP_BIT};
              if (SINGLE && (bit_idx == PEN_IDX)) begin
                frame_done <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (!SINGLE && last_bit && (cnt == CNT_PRE)) begin
              frame_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Loading a frame overrides the end-of-frame return to idle above.
      if (pop) begin
        state    <= SEND;
        shreg    <= next_frame;
        cnt      <= '0;
        bit_idx  <= '0;
        ser_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

  localparam int BITC  = 4;
  localparam int FLEN  = 16 * BITC;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic [3:0] in_opcode;
  logic       ser_out;
  logic       ser_busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_result_serializer #(
    .DEPTH      (4),
    .BIT_CYCLES (BITC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_opcode   (in_opcode),
    .ser_out     (ser_out),
    .ser_busy    (ser_busy),
    .frame_done  (frame_done),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Line monitor: decodes frames from ser_out, one sample per clock.
  logic [15:0] frames[$];
  bit          frame_bad_q[$];
  int          fd_cyc[$];
  int          fd_err   = 0;
  int          idle_err = 0;
  int          pos = 0;
  bit          bad = 0;
  logic [15:0] cur = '0;

  always @(negedge clk) begin
    int bi;
    if (rst) begin
      pos = 0;
      bad = 0;
    end else if (ser_busy !== 1'b1) begin
      pos = 0;
      bad = 0;
      if (frame_done !== 1'b0) fd_err++;
      if (ser_out !== 1'b1) idle_err++;
    end else begin
      bi = pos / BITC;
      if (pos % BITC == 0) cur[15-bi] = ser_out;
      else if (ser_out !== cur[15-bi]) bad = 1;
      if (frame_done !== ((pos == FLEN-1) ? 1'b1 : 1'b0)) fd_err++;
      if (frame_done === 1'b1) fd_cyc.push_back(cyc);
      pos++;
      if (pos == FLEN) begin
        frames.push_back(cur);
        frame_bad_q.push_back(bad);
        pos = 0;
        bad = 0;
      end
    end
  end

  task automatic clear_mon();
    frames.delete();
    frame_bad_q.delete();
    fd_cyc.delete();
  endtask

  task automatic drive_entry(input logic [3:0] op, input logic [7:0] res,
                             input logic c, input logic v);
    in_opcode   = op;
    in_result   = res;
    in_carry    = c;
    in_overflow = v;
  endtask

  task automatic wait_frames(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (frames.size() >= n) break;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] frame_at(input int i);
    if (i < frames.size()) return frames[i];
    return 'x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    drive_entry(4'h0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL reset_ser_out got %b exp 1", ser_out); end
    checks++; if (ser_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ser_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_add();
    int start_cyc;
    clear_mon();
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h05, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL add_count_after_push got %0d exp 1", fifo_count); end
    checks++; if (ser_busy !== 1'b0) begin errors++; $display("FAIL add_busy_before_pop got %b exp 0", ser_busy); end
    @(negedge clk);
    start_cyc = cyc;
    checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL add_start_bit got %b exp 0", ser_out); end
    checks++; if (ser_busy !== 1'b1) begin errors++; $display("FAIL add_busy got %b exp 1", ser_busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL add_count_after_pop got %0d exp 0", fifo_count); end
    wait_frames(1, FLEN + 20);
    checks++; if (frames.size() != 1) begin errors++; $display("FAIL add_frame_count got %0d exp 1", frames.size()); end
    checks++; if (frame_at(0) !== 16'h000B) begin errors++; $display("FAIL add_frame got %h exp 000b", frame_at(0)); end
    checks++; if (frame_bad_q.size() != 1 || frame_bad_q[0] != 1'b0) begin errors++; $display("FAIL add_bit_hold got unstable exp stable"); end
    checks++; if (fd_cyc.size() != 1 || fd_cyc[0] != start_cyc + FLEN - 1) begin errors++; $display("FAIL add_done_cycle got %0d pulses exp 1 at %0d", fd_cyc.size(), start_cyc + FLEN - 1); end
    repeat (2) @(negedge clk);
    checks++; if (ser_busy !== 1'b0 || ser_out !== 1'b1) begin errors++; $display("FAIL add_idle got busy=%b out=%b exp busy=0 out=1", ser_busy, ser_out); end
  endtask

  task automatic test_flags();
    clear_mon();
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h00, 1'b1, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_frames(1, FLEN + 20);
    checks++; if (frame_at(0) !== 16'h0601) begin errors++; $display("FAIL flags_frame got %h exp 0601", frame_at(0)); end
    checks++; if (frame_bad_q.size() != 1 || frame_bad_q[0] != 1'b0) begin errors++; $display("FAIL flags_bit_hold got unstable exp stable"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [5] = '{4'd2, 4'd3, 4'd4, 4'd8, 4'd6};
    logic [7:0]  res [5] = '{8'h0F, 8'h31, 8'h04, 8'hAB, 8'h06};
    logic [15:0] expf[5] = '{16'h101F, 16'h1863, 16'h2009, 16'h4157, 16'h300D};
    int refused_bad;
    clear_mon();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive_entry(ops[i], res[i], 1'b0, 1'b0);
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b exp 1", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_peak_count got %0d exp 4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
    drive_entry(4'h1, 8'hFF, 1'b1, 1'b1);
    refused_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (fifo_count !== 3'd4 || in_ready !== 1'b0) refused_bad++;
    end
    in_valid = 1'b0;
    checks++; if (refused_bad != 0) begin errors++; $display("FAIL b2b_refused got %0d bad cycles exp 0", refused_bad); end
    wait_frames(5, 5 * FLEN + 40);
    for (int i = 0; i < 5; i++) begin
      checks++; if (frame_at(i) !== expf[i]) begin errors++; $display("FAIL b2b_frame_%0d got %h exp %h", i, frame_at(i), expf[i]); end
    end
    checks++; if (fd_cyc.size() != 5) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 5", fd_cyc.size()); end
    for (int i = 1; i < 5; i++) begin
      if (i < fd_cyc.size()) begin
        checks++; if (fd_cyc[i] - fd_cyc[i-1] != FLEN) begin errors++; $display("FAIL b2b_spacing_%0d got %0d exp %0d", i, fd_cyc[i] - fd_cyc[i-1], FLEN); end
      end
    end
    repeat (FLEN + 10) @(negedge clk);
    checks++; if (frames.size() != 5) begin errors++; $display("FAIL b2b_no_extra got %0d frames exp 5", frames.size()); end
  endtask

  task automatic test_simul_push_pop();
    bit seen;
    clear_mon();
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h05, 1'b0, 1'b0); in_valid = 1'b1;
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_entry(4'h2, 8'h0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL spp_count_before got %0d exp 2", fifo_count); end
    seen = 0;
    for (int i = 0; i < FLEN + 20; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL spp_stop_wait got timeout exp frame_done"); end
    drive_entry(4'h6, 8'h06, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL spp_count_after got %0d exp 2", fifo_count); end
    wait_frames(4, 4 * FLEN + 40);
    checks++; if (frame_at(0) !== 16'h000B) begin errors++; $display("FAIL spp_frame_0 got %h exp 000b", frame_at(0)); end
    checks++; if (frame_at(1) !== 16'h0601) begin errors++; $display("FAIL spp_frame_1 got %h exp 0601", frame_at(1)); end
    checks++; if (frame_at(2) !== 16'h101F) begin errors++; $display("FAIL spp_frame_2 got %h exp 101f", frame_at(2)); end
    checks++; if (frame_at(3) !== 16'h300D) begin errors++; $display("FAIL spp_frame_3 got %h exp 300d", frame_at(3)); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    clear_mon();
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h05, 1'b0, 1'b0); in_valid = 1'b1;
    @(posedge clk); #1;
    drive_entry(4'h0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_entry(4'h2, 8'h0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ser_busy === 1'b1) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_start got timeout exp busy"); end
    repeat (7 * BITC) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL rmid_ser_out got %b exp 1", ser_out); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", fifo_count); end
    checks++; if (ser_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", ser_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    repeat (3 * FLEN) @(negedge clk);
    checks++; if (frames.size() != 0) begin errors++; $display("FAIL rmid_no_frames got %0d exp 0", frames.size()); end
    @(posedge clk); #1;
    drive_entry(4'h8, 8'hAB, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_frames(1, FLEN + 20);
    checks++; if (frame_at(0) !== 16'h4157) begin errors++; $display("FAIL rmid_fresh_frame got %h exp 4157", frame_at(0)); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_line_protocol();
    checks++; if (fd_err != 0) begin errors++; $display("FAIL proto_frame_done got %0d stray exp 0", fd_err); end
    checks++; if (idle_err != 0) begin errors++; $display("FAIL proto_idle_high got %0d low cycles exp 0", idle_err); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_flags();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_line_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
Downstream stage of the 4-bit ALU. Each cycle it can capture one registered ALU result (8-bit result, carry, overflow, 4-bit opcode tag) into a small FIFO. It then shifts each entry out as a fixed 16-bit frame on a single serial pin, so a host can read results over one wire. It decouples the ALU's one-result-per-cycle rate from the slower serial line.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BIT_CYCLES, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  FIFO can accept (= not full)
in_result  input  8  ALU result byte
in_carry  input  1  ALU carry/borrow flag
in_overflow  input  1  ALU signed-overflow flag
in_opcode  input  4  opcode that produced the result (tag)
ser_out  output  1  serial data; idles high
ser_busy  output  1  high while a frame is on the line
frame_done  output  1  one-cycle pulse on the final cycle of a stop bit
fifo_count  output  $clog2(DEPTH+1)  entries currently stored

Behaviour:
- Reset (rst=1 at a clk edge, highest priority, also mid-frame): FIFO emptied, pointers and fifo_count=0, FSM=IDLE, ser_out=1, ser_busy=0, frame_done=0, in_ready=1. Any frame in progress is abandoned and is not resumed.
- Push: accepted when in_valid && in_ready. Entry = {opcode, carry, overflow, result} (14 bits).
- in_ready = (fifo_count != DEPTH), combinational from registered count. When full, a push is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- Frame: 16 bits, sent in this order: start(0), opcode[3:0] MSB-first, carry, overflow, result[7:0] MSB-first, stop(1).
- Each bit is held exactly BIT_CYCLES cycles. A bit-cycle counter and a 4-bit bit index are used.
- FSM has two states, IDLE and SEND.
  - IDLE: ser_out=1, ser_busy=0. If fifo_count>0, pop the head into a 16-bit shift register and go to SEND. The start bit appears on ser_out on the next cycle (1-cycle latency from IDLE-with-data).
  - SEND: ser_busy=1; ser_out = current frame bit (registered). On the last cycle of the stop bit, frame_done=1.
  - At that stop-bit cycle, if fifo_count>0, pop and load the next frame directly with no idle gap; otherwise return to IDLE.
- Frame period is therefore exactly 16*BIT_CYCLES cycles back-to-back.
- An entry pushed into an empty FIFO while in IDLE is popped on the following cycle. Its start bit is visible 2 cycles after the push edge.
- All outputs are registered except in_ready. There are no X states: all regs are reset.

Decomposition:
- Shared package alu_pkg: opcode constants (ADD=0 ... ENC=8), FRAME_W=16, PAYLOAD_W=14, START_BIT=0, STOP_BIT=1, state enum {IDLE, SEND}.
- One sub-module, result_fifo (parameter DEPTH, width PAYLOAD_W): push/pop/full/empty/count, synchronous active-high reset.
- The serializer FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> ser_out=1, ser_busy=0, in_ready=1, fifo_count=0, frame_done=0.
- Single ADD: push opcode=0, result=0x05, carry=0, overflow=0 with BIT_CYCLES=4 -> ser_out sequence 0,0000,0,0,00000101,1, each bit held 4 cycles. frame_done pulses once at cycle 64 of the frame; the line then returns to IDLE high.
- Flags: push opcode=0, result=0x00, carry=1, overflow=1 (the 8+8 case) -> bits 0,0000,1,1,00000000,1.
- Full/back-to-back: push 5 entries on consecutive cycles while idle (MUL 0x0F, DIV 0x31, AND 0x04, ENC 0xAB, XOR 0x06). The first is popped immediately, so all 5 are accepted and fifo_count peaks at 4. A further push is refused (in_ready=0) until the next stop bit. Frames go out in order with no idle gap; frame_done pulses 5 times, 64 cycles apart.
- Simultaneous push/pop: FIFO holds 2 entries; push on the stop-bit cycle that pops -> fifo_count stays 2 and both entries are later sent in order.
- Reset mid-frame: assert rst at bit 7 of a frame with 2 queued entries -> next cycle ser_out=1, fifo_count=0, ser_busy=0. No further frames are sent; a fresh push then transmits normally.
